// File: rtl/quad_pkg.sv
// Shared definitions for the quadrature decoder and the directional counter it feeds.
// Holds the pin-state encodings, direction codes and the Gray-code step classifier.
`timescale 1ns/1ps
package quad_pkg;

  typedef enum logic [1:0] {
    S00 = 2'b00,
    S01 = 2'b01,
    S10 = 2'b10,
    S11 = 2'b11
  } quad_state_t;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_UP,
    STEP_DN,
    STEP_BAD
  } quad_step_t;

  // Successor of a state when A leads B: 00 -> 10 -> 11 -> 01 -> 00.
  function automatic quad_state_t next_up(input quad_state_t s);
    quad_state_t n;
    n = S00;
    case (s)
      S00:     n = S10;
      S10:     n = S11;
      S11:     n = S01;
      S01:     n = S00;
      default: n = S00;
    endcase
    return n;
  endfunction

  function automatic quad_step_t classify_step(input quad_state_t prev, input quad_state_t cur);
    quad_step_t step;
    if (prev == cur)
      step = STEP_NONE;
    else if ((prev ^ cur) == 2'b11)
      step = STEP_BAD;
    else if (cur == next_up(prev))
      step = STEP_UP;
    else
      step = STEP_DN;
    return step;
  endfunction

endpackage

// File: rtl/quad_filter.sv
// Two-flop synchroniser followed by a persistence filter for one encoder pin.
// The filtered level only follows the pin after it has disagreed for FILT_LEN consecutive cycles.
`timescale 1ns/1ps
module quad_filter #(
  parameter int FILT_LEN = 4,
  parameter int FILT_W   = $clog2(FILT_LEN + 1)
) (
  input  logic CLK,
  input  logic RST,
  input  logic D,
  output logic Q
);

  logic              s1;
  logic              s2;
  logic [FILT_W-1:0] cnt;

  // Any return to agreement restarts the count, so short glitches never reach Q.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      Q   <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= D;
      s2 <= s1;
      if (s2 == Q) begin
        cnt <= '0;
      end else if (cnt == FILT_W'(FILT_LEN - 1)) begin
        Q   <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/quad_decoder.sv
// x4 quadrature decoder: filtered A/B pins in, one-cycle EN pulse plus DIR out, sticky ERR
// on double transitions. Stays disarmed for a short window after reset so idle pins never count.
`timescale 1ns/1ps
module quad_decoder
  import quad_pkg::*;
#(
  parameter int FILT_LEN = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic QA,
  input  logic QB,
  input  logic ERR_CLR,
  output logic EN,
  output logic DIR,
  output logic ERR
);

  localparam int FILT_W       = $clog2(FILT_LEN + 1);
  localparam int START_CYCLES = FILT_LEN + 3;
  localparam int START_W      = $clog2(START_CYCLES + 1);

  logic               filt_a;
  logic               filt_b;
  quad_state_t        st;
  quad_state_t        st_next;
  quad_step_t         step;
  logic               armed;
  logic               armed_next;
  logic [START_W-1:0] start_cnt;
  logic [START_W-1:0] start_cnt_next;
  logic               en_next;
  logic               dir_next;
  logic               err_next;

  quad_filter #(
    .FILT_LEN (FILT_LEN),
    .FILT_W   (FILT_W)
  ) u_filter_a (
    .CLK (CLK),
    .RST (RST),
    .D   (QA),
    .Q   (filt_a)
  );

  quad_filter #(
    .FILT_LEN (FILT_LEN),
    .FILT_W   (FILT_W)
  ) u_filter_b (
    .CLK (CLK),
    .RST (RST),
    .D   (QB),
    .Q   (filt_b)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      st        <= S00;
      armed     <= 1'b0;
      start_cnt <= '0;
      EN        <= 1'b0;
      DIR       <= DIR_UP;
      ERR       <= 1'b0;
    end else begin
      st        <= st_next;
      armed     <= armed_next;
      start_cnt <= start_cnt_next;
      EN        <= en_next;
      DIR       <= dir_next;
      ERR       <= err_next;
    end
  end

  // The state always resynchronises to the filtered pins; only armed steps produce events.
  // A clear is applied first so that an illegal step in the same cycle overrides it.
  always_comb begin
    st_next        = quad_state_t'({filt_a, filt_b});
    step           = classify_step(st, st_next);
    armed_next     = armed;
    start_cnt_next = start_cnt;
    en_next        = 1'b0;
    dir_next       = DIR;
    err_next       = ERR_CLR ? 1'b0 : ERR;

    if (!armed) begin
      if (start_cnt == START_W'(START_CYCLES - 1))
        armed_next = 1'b1;
      else
        start_cnt_next = start_cnt + 1'b1;
    end else begin
      case (step)
        STEP_UP: begin
          en_next  = 1'b1;
          dir_next = DIR_UP;
        end
        STEP_DN: begin
          en_next  = 1'b1;
          dir_next = DIR_DN;
        end
        STEP_BAD: err_next = 1'b1;
        default:  en_next  = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder: stimulus pushes expected EN events (direction and arrival
// cycle) into a queue, and a negedge monitor pops and checks each EN the DUT raises.
`timescale 1ns/1ps
module tb_quad_decoder;
  import quad_pkg::*;

  localparam int FILT_LEN = 4;
  localparam int LATENCY  = FILT_LEN + 3;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic QA = 1'b0;
  logic QB = 1'b0;
  logic ERR_CLR = 1'b0;
  logic EN;
  logic DIR;
  logic ERR;

  typedef struct {
    logic dir;
    int   cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  quad_decoder #(
    .FILT_LEN (FILT_LEN)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .QA      (QA),
    .QB      (QB),
    .ERR_CLR (ERR_CLR),
    .EN      (EN),
    .DIR     (DIR),
    .ERR     (ERR)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Every EN pulse must match the oldest outstanding expectation in direction and cycle.
  always @(negedge CLK) begin
    if (RST && EN) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected_en: got EN=1 DIR=%0b at cycle %0d, expected no EN", DIR, cyc);
      end else begin
        mon_e = sb.pop_front();
        n_checks++;
        if (DIR !== mon_e.dir) begin
          n_fail++;
          $display("[TB] FAIL en_dir: got DIR=%0b expected %0b at cycle %0d", DIR, mon_e.dir, cyc);
        end
        n_checks++;
        if (cyc != mon_e.cyc) begin
          n_fail++;
          $display("[TB] FAIL en_cycle: got EN at cycle %0d expected cycle %0d", cyc, mon_e.cyc);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic actual, input logic expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0b expected %0b", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic a, input logic b, input int hold,
                               input logic exp_en, input logic exp_dir);
    @(negedge CLK);
    QA = a;
    QB = b;
    if (exp_en) sb.push_back('{dir: exp_dir, cyc: cyc + LATENCY});
    repeat (hold - 1) @(negedge CLK);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    QA = 1'b1;
    QB = 1'b1;
    #3 RST = 1'b0;
    repeat (2) @(negedge CLK);
    checkOutput("rst_en", EN, 1'b0);
    checkOutput("rst_dir", DIR, 1'b0);
    checkOutput("rst_err", ERR, 1'b0);

    // Pins idle at 11 through reset release: no event may appear.
    RST = 1'b1;
    repeat (50) @(negedge CLK);
    checkOutput("idle_en", EN, 1'b0);
    checkOutput("idle_err", ERR, 1'b0);

    // Walk legally from 11 back to 00, then a full up cycle.
    applyStimulus(1'b0, 1'b1, 10, 1'b1, DIR_UP);
    applyStimulus(1'b0, 1'b0, 10, 1'b1, DIR_UP);
    applyStimulus(1'b1, 1'b0, 10, 1'b1, DIR_UP);
    applyStimulus(1'b1, 1'b1, 10, 1'b1, DIR_UP);
    applyStimulus(1'b0, 1'b1, 10, 1'b1, DIR_UP);
    applyStimulus(1'b0, 1'b0, 10, 1'b1, DIR_UP);

    // Full down cycle.
    applyStimulus(1'b0, 1'b1, 10, 1'b1, DIR_DN);
    applyStimulus(1'b1, 1'b1, 10, 1'b1, DIR_DN);
    applyStimulus(1'b1, 1'b0, 10, 1'b1, DIR_DN);
    applyStimulus(1'b0, 1'b0, 10, 1'b1, DIR_DN);

    // Filter boundary: 3-cycle pulse rejected, 4-cycle pulse accepted, return counts down.
    applyStimulus(1'b1, 1'b0, 3, 1'b0, DIR_UP);
    applyStimulus(1'b0, 1'b0, 10, 1'b0, DIR_UP);
    applyStimulus(1'b1, 1'b0, 4, 1'b1, DIR_UP);
    applyStimulus(1'b0, 1'b0, 12, 1'b1, DIR_DN);

    // Double transition 00 -> 11 sets ERR without counting.
    applyStimulus(1'b1, 1'b1, 10, 1'b0, DIR_UP);
    checkOutput("err_set", ERR, 1'b1);
    @(negedge CLK) ERR_CLR = 1'b1;
    @(negedge CLK) ERR_CLR = 1'b0;
    checkOutput("err_clr", ERR, 1'b0);

    // Clear coincident with a new illegal step 11 -> 00: set wins.
    applyStimulus(1'b0, 1'b0, LATENCY - 1, 1'b0, DIR_UP);
    @(negedge CLK) ERR_CLR = 1'b1;
    @(negedge CLK) ERR_CLR = 1'b0;
    checkOutput("err_set_wins", ERR, 1'b1);
    repeat (5) @(negedge CLK);
    checkOutput("err_sticky", ERR, 1'b1);
    checkOutput("dir_before_rst", DIR, DIR_DN);

    // Reset while QA's filter count sits at 2; the pending edge must vanish.
    applyStimulus(1'b1, 1'b0, 4, 1'b0, DIR_UP);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    checkOutput("midrst_en", EN, 1'b0);
    checkOutput("midrst_dir", DIR, 1'b0);
    checkOutput("midrst_err", ERR, 1'b0);
    @(negedge CLK) RST = 1'b1;
    repeat (20) @(negedge CLK);
    checkOutput("post_rst_err", ERR, 1'b0);
    applyStimulus(1'b0, 1'b0, 12, 1'b1, DIR_DN);

    repeat (10) @(negedge CLK);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL sb_empty: got %0d outstanding EN events expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
